// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

   typedef enum logic {IDLE, BUSY} state_e;

   typedef enum logic {SEL_IF, SEL_D} port_e;

   localparam logic [2:0] FUNCT3_LW = 3'b010;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on contention, the port that was not served last wins.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_e      last,
   output logic [1:0] gnt
);

   // bit 0 = fetch, bit 1 = data
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last == SEL_D) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// instruction fetch and load/store; one access in flight at a time.
module mem_arbiter #(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_funct3,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [2:0]  m_funct3,
   input  logic [31:0] m_rdata
);
   import mem_arb_pkg::*;

   if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
      $error("mem_arbiter: MEM_LAT must be in 1..15");
   end

   state_e     state;
   port_e      last;
   port_e      sel;
   logic [3:0] cnt;
   logic [1:0] pick;
   logic       can_issue;
   logic       done;

   arb_rr2 u_pick (
      .req  ({d_req, if_req}),
      .last (last),
      .gnt  (pick)
   );

   // Grants are combinational from req; gating with reset keeps every output
   // at 0 while reset is held even if requests stay asserted.
   assign can_issue = (state == IDLE) && !reset;
   assign done      = (state == BUSY) && (cnt == 4'(MEM_LAT));

   always_comb begin
      if_gnt   = 1'b0;
      d_gnt    = 1'b0;
      m_req    = 1'b0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      m_funct3 = '0;
      if (can_issue) begin
         if (pick[0]) begin
            if_gnt   = 1'b1;
            m_req    = 1'b1;
            m_addr   = if_addr;
            m_funct3 = FUNCT3_LW;
         end else if (pick[1]) begin
            d_gnt    = 1'b1;
            m_req    = 1'b1;
            m_we     = d_we;
            m_addr   = d_addr;
            m_wdata  = d_wdata;
            m_funct3 = d_funct3;
         end
      end
   end

   always_comb begin
      if_rvalid = done && (sel == SEL_IF);
      d_rvalid  = done && (sel == SEL_D);
      if_rdata  = if_rvalid ? m_rdata : '0;
      d_rdata   = d_rvalid  ? m_rdata : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         last  <= SEL_D;
         sel   <= SEL_IF;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick != 2'b00) begin
                  sel   <= pick[0] ? SEL_IF : SEL_D;
                  last  <= pick[0] ? SEL_IF : SEL_D;
                  cnt   <= 4'd1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + 4'd1;
               if (done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MEM_LAT = 2, plus 1 and 15 builds).
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [2:0]  d_funct3 = '0;
   logic [31:0] m_rdata = '0;

   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, m_req, m_we;
   logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
   logic [2:0]  m_funct3;

   logic        if_gnt_l1, if_rvalid_l1, d_gnt_l1, d_rvalid_l1, m_req_l1, m_we_l1;
   logic [31:0] if_rdata_l1, d_rdata_l1, m_addr_l1, m_wdata_l1;
   logic [2:0]  m_funct3_l1;

   logic        if_gnt_l15, if_rvalid_l15, d_gnt_l15, d_rvalid_l15, m_req_l15, m_we_l15;
   logic [31:0] if_rdata_l15, d_rdata_l15, m_addr_l15, m_wdata_l15;
   logic [2:0]  m_funct3_l15;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   mem_arbiter #(.MEM_LAT(2)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_funct3(d_funct3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_funct3(m_funct3), .m_rdata(m_rdata)
   );

   mem_arbiter #(.MEM_LAT(1)) dut_l1 (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_l1),
      .if_rvalid(if_rvalid_l1), .if_rdata(if_rdata_l1),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_funct3(d_funct3), .d_gnt(d_gnt_l1), .d_rvalid(d_rvalid_l1), .d_rdata(d_rdata_l1),
      .m_req(m_req_l1), .m_we(m_we_l1), .m_addr(m_addr_l1), .m_wdata(m_wdata_l1),
      .m_funct3(m_funct3_l1), .m_rdata(m_rdata)
   );

   mem_arbiter #(.MEM_LAT(15)) dut_l15 (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_l15),
      .if_rvalid(if_rvalid_l15), .if_rdata(if_rdata_l15),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_funct3(d_funct3), .d_gnt(d_gnt_l15), .d_rvalid(d_rvalid_l15), .d_rdata(d_rdata_l15),
      .m_req(m_req_l15), .m_we(m_we_l15), .m_addr(m_addr_l15), .m_wdata(m_wdata_l15),
      .m_funct3(m_funct3_l15), .m_rdata(m_rdata)
   );

   // Advance to 1 time unit after the next rising edge; inputs change here.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_reset();
      if_req = 1'b0;
      d_req  = 1'b0;
      reset  = 1'b1;
      step();
      step();
      reset  = 1'b0;
   endtask

   task automatic test_reset();
      logic [103:0] all_out;
      if_req  = 1'b1;
      d_req   = 1'b1;
      if_addr = 32'h0000_0abc;
      d_addr  = 32'h0000_0def;
      m_rdata = 32'h1234_5678;
      step();
      #1;
      all_out = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                 m_req, m_we, m_addr[0], m_funct3};
      tests++;
      if (all_out !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      tests++;
      if ({m_addr, m_wdata} !== 64'h0) begin
         fails++;
         $display("FAIL reset_maddr: got %h expected 0", {m_addr, m_wdata});
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      reset  = 1'b0;
      step();
   endtask

   task automatic test_lone_fetch();
      if_req  = 1'b1;
      if_addr = 32'h0000_0010;
      #1;
      tests++;
      if ({if_gnt, d_gnt, m_req, m_we, m_addr, m_funct3, m_wdata} !==
          {1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 3'b010, 32'h0}) begin
         fails++;
         $display("FAIL fetch_issue: got gnt=%b m_req=%b we=%b addr=%h f3=%b wd=%h expected gnt=1 m_req=1 we=0 addr=10 f3=010 wd=0",
                  if_gnt, m_req, m_we, m_addr, m_funct3, m_wdata);
      end
      step();
      if_req  = 1'b0;
      m_rdata = 32'h5555_aaaa;
      #1;
      tests++;
      if ({if_rvalid, if_rdata, if_gnt, m_req} !== 35'h0) begin
         fails++;
         $display("FAIL fetch_busy1: got rvalid=%b rdata=%h gnt=%b m_req=%b expected all 0",
                  if_rvalid, if_rdata, if_gnt, m_req);
      end
      step();
      m_rdata = 32'hcafe_0001;
      #1;
      tests++;
      if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, 32'hcafe_0001, 1'b0}) begin
         fails++;
         $display("FAIL fetch_rvalid: got rvalid=%b rdata=%h d_rvalid=%b expected 1 cafe0001 0",
                  if_rvalid, if_rdata, d_rvalid);
      end
      step();
      d_req    = 1'b1;
      d_we     = 1'b0;
      d_addr   = 32'h0000_0020;
      d_funct3 = 3'b010;
      #1;
      tests++;
      if ({if_rvalid, d_gnt, m_req, m_addr} !== {1'b0, 1'b1, 1'b1, 32'h20}) begin
         fails++;
         $display("FAIL fetch_idle_again: got rvalid=%b d_gnt=%b m_req=%b addr=%h expected 0 1 1 20",
                  if_rvalid, d_gnt, m_req, m_addr);
      end
      step();
      d_req = 1'b0;
      step();
      step();
   endtask

   task automatic test_simultaneous();
      pulse_reset();
      if_req  = 1'b1;
      if_addr = 32'h0000_0040;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h0000_0200;
      #1;
      tests++;
      if ({if_gnt, d_gnt, m_addr} !== {1'b1, 1'b0, 32'h40}) begin
         fails++;
         $display("FAIL simul_first: got if_gnt=%b d_gnt=%b addr=%h expected 1 0 40",
                  if_gnt, d_gnt, m_addr);
      end
      step();
      if_req = 1'b0;
      #1;
      tests++;
      if (d_gnt !== 1'b0) begin
         fails++;
         $display("FAIL simul_d_wait: got d_gnt=%b expected 0", d_gnt);
      end
      step();
      step();
      #1;
      tests++;
      if ({d_gnt, m_req, m_we, m_addr} !== {1'b1, 1'b1, 1'b0, 32'h200}) begin
         fails++;
         $display("FAIL simul_d_gnt: got d_gnt=%b m_req=%b we=%b addr=%h expected 1 1 0 200",
                  d_gnt, m_req, m_we, m_addr);
      end
      step();
      d_req = 1'b0;
      #1;
      tests++;
      if (d_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL simul_d_early: got d_rvalid=%b expected 0", d_rvalid);
      end
      step();
      m_rdata = 32'h0bad_f00d;
      #1;
      tests++;
      if ({d_rvalid, d_rdata, if_rvalid} !== {1'b1, 32'h0bad_f00d, 1'b0}) begin
         fails++;
         $display("FAIL simul_d_rvalid: got d_rvalid=%b d_rdata=%h if_rvalid=%b expected 1 0badf00d 0",
                  d_rvalid, d_rdata, if_rvalid);
      end
      step();
   endtask

   task automatic test_store();
      d_req    = 1'b1;
      d_we     = 1'b1;
      d_addr   = 32'h0000_0100;
      d_wdata  = 32'hdead_beef;
      d_funct3 = 3'b000;
      #1;
      tests++;
      if ({d_gnt, m_req, m_we, m_addr, m_wdata, m_funct3} !==
          {1'b1, 1'b1, 1'b1, 32'h100, 32'hdead_beef, 3'b000}) begin
         fails++;
         $display("FAIL store_issue: got gnt=%b req=%b we=%b addr=%h wd=%h f3=%b expected 1 1 1 100 deadbeef 000",
                  d_gnt, m_req, m_we, m_addr, m_wdata, m_funct3);
      end
      step();
      d_req = 1'b0;
      d_we  = 1'b0;
      #1;
      tests++;
      if (d_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL store_early: got d_rvalid=%b expected 0", d_rvalid);
      end
      step();
      tests++;
      if (d_rvalid !== 1'b1) begin
         fails++;
         $display("FAIL store_rvalid: got d_rvalid=%b expected 1", d_rvalid);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [4:0] got;
      logic [4:0] exp;
      // last = D here, so fetch wins first; accesses issue every 3 cycles
      for (int c = 0; c < 12; c++) begin
         if_req  = (c < 10);
         d_req   = (c < 10);
         if_addr = 32'h0000_1000 + 32'(c);
         d_addr  = 32'h0000_2000 + 32'(c);
         d_we    = 1'b0;
         #1;
         got = {m_req, if_gnt, d_gnt, if_rvalid, d_rvalid};
         exp = {(c % 3 == 0) && (c < 10), (c % 6 == 0), (c % 6 == 3),
                (c % 6 == 2), (c % 6 == 5)};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL b2b_cycle%0d: got req/ifg/dg/ifv/dv=%b expected %b", c, got, exp);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [71:0] all_out;
      if_req  = 1'b1;
      if_addr = 32'h0000_0300;
      #1;
      tests++;
      if (if_gnt !== 1'b1) begin
         fails++;
         $display("FAIL rst_busy_gnt: got if_gnt=%b expected 1", if_gnt);
      end
      step();
      if_req  = 1'b1;
      d_req   = 1'b1;
      m_rdata = 32'h7777_7777;
      reset   = 1'b1;
      #1;
      all_out = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, m_req, m_we, m_funct3, m_addr[31:1]};
      tests++;
      if (all_out !== '0 || d_rdata !== 32'h0) begin
         fails++;
         $display("FAIL rst_busy_async: got %h d_rdata=%h expected 0", all_out, d_rdata);
      end
      step();
      tests++;
      if ({if_rvalid, if_rdata, d_rvalid} !== 34'h0) begin
         fails++;
         $display("FAIL rst_busy_no_rvalid: got rvalid=%b rdata=%h expected 0", if_rvalid, if_rdata);
      end
      step();
      if_req  = 1'b0;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h0000_0044;
      reset   = 1'b0;
      #1;
      tests++;
      if ({d_gnt, m_req, m_addr} !== {1'b1, 1'b1, 32'h44}) begin
         fails++;
         $display("FAIL rst_after_gnt: got d_gnt=%b m_req=%b addr=%h expected 1 1 44", d_gnt, m_req, m_addr);
      end
      step();
      d_req = 1'b0;
      step();
      m_rdata = 32'h4444_0044;
      #1;
      tests++;
      if ({d_rvalid, d_rdata} !== {1'b1, 32'h4444_0044}) begin
         fails++;
         $display("FAIL rst_after_rvalid: got d_rvalid=%b d_rdata=%h expected 1 44440044", d_rvalid, d_rdata);
      end
      step();
   endtask

   task automatic test_latency_extremes();
      int first_l1;
      int first_l15;
      int n_l1;
      int n_l15;
      logic [31:0] rd_l15;
      first_l1  = -1;
      first_l15 = -1;
      n_l1      = 0;
      n_l15     = 0;
      rd_l15    = '0;
      pulse_reset();
      m_rdata = 32'h1515_0f0f;
      if_req  = 1'b1;
      if_addr = 32'h0000_0500;
      #1;
      tests++;
      if ({if_gnt_l1, if_gnt_l15, m_addr_l15} !== {1'b1, 1'b1, 32'h500}) begin
         fails++;
         $display("FAIL lat_gnt: got l1=%b l15=%b addr=%h expected 1 1 500", if_gnt_l1, if_gnt_l15, m_addr_l15);
      end
      step();
      if_req = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         #1;
         if (if_rvalid_l1) begin
            n_l1++;
            if (first_l1 < 0) first_l1 = c;
         end
         if (if_rvalid_l15) begin
            n_l15++;
            if (first_l15 < 0) first_l15 = c;
            rd_l15 = if_rdata_l15;
         end
         step();
      end
      tests++;
      if (first_l1 != 1 || n_l1 != 1) begin
         fails++;
         $display("FAIL lat1_offset: got offset=%0d pulses=%0d expected offset=1 pulses=1", first_l1, n_l1);
      end
      tests++;
      if (first_l15 != 15 || n_l15 != 1) begin
         fails++;
         $display("FAIL lat15_offset: got offset=%0d pulses=%0d expected offset=15 pulses=1", first_l15, n_l15);
      end
      tests++;
      if (rd_l15 !== 32'h1515_0f0f) begin
         fails++;
         $display("FAIL lat15_rdata: got %h expected 15150f0f", rd_l15);
      end
   endtask

   initial begin
      test_reset();
      test_lone_fetch();
      test_simultaneous();
      test_store();
      test_back_to_back();
      test_reset_mid_busy();
      test_latency_extremes();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, fixed-latency unified memory between the cpu's instruction-fetch port and its load/store port, replacing the separate instr_mem/data_mem pair in the multicycle core. It arbitrates round-robin and issues one access at a time. It counts the memory latency and returns the read data to the granted requester with a one-cycle valid pulse.

## Interface
Parameters:
- MEM_LAT, 2, cycles from issue to valid m_rdata; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch accepted (one-cycle pulse).
- if_rvalid  out  1  fetch data valid (one-cycle pulse).
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_funct3  in  3  access size/sign, passed through to memory.
- d_gnt  out  1  data accepted (one-cycle pulse).
- d_rvalid  out  1  data access complete (one-cycle pulse; also pulses for stores).
- d_rdata  out  32  load data.
- m_req  out  1  memory issue strobe.
- m_we  out  1  memory write enable.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_funct3  out  3  memory access size.
- m_rdata  in  32  memory read data, valid MEM_LAT cycles after the m_req cycle.

## Operation
- FSM states: IDLE, BUSY. There is one 4-bit latency counter `cnt` and one register `last` (values IF or D).
- IDLE, no request: all strobes are 0 and m_* are 0.
- IDLE with only one req high: select that port.
- IDLE with both reqs high: select the port not equal to `last`.
- On a selection, in the same cycle:
  - assert m_req and the selected gnt.
  - drive m_* from the selected port.
  - on the next edge: `last` takes the selected port, sel is registered, `cnt` is set to 1, and the FSM goes to BUSY.
- Fetch issue fields: m_we=0, m_funct3=3'b010 (word), m_wdata=0.
- BUSY:
  - m_req=0 and both gnts are 0. Requests are ignored but must stay held.
  - `cnt` increments each cycle.
  - In the cycle where `cnt`==MEM_LAT, pulse the rvalid of the registered sel. The matching rdata equals m_rdata in that cycle; d_rdata is don't-care for stores.
  - The FSM returns to IDLE on the next edge.
- Outside its rvalid cycle, each rdata output is 0.
- A req dropped before its gnt is a legal withdrawal and causes no side effect.
- Throughput: one access per MEM_LAT+1 cycles. There is no back-to-back issue.

## Timing
- Reset value of every output is 0. Reset also sets state=IDLE, cnt=0 and last=D, so the first simultaneous request goes to fetch.
- Grant latency: 0 cycles from a req in IDLE. gnt and m_req are combinational from the req inputs and state.
- Response latency: rvalid arrives MEM_LAT cycles after the gnt cycle.
- Reset asserted mid-BUSY: outputs go to 0 immediately and the in-flight rvalid is never produced. A store already issued may still complete in memory; the arbiter does not cancel it.
- MEM_LAT outside 1..15 is an elaboration error.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum {IDLE, BUSY}
  - the port enum {SEL_IF, SEL_D}
  - the constant FUNCT3_LW = 3'b010
- Sub-module `arb_rr2`: a combinational 2-way round-robin picker with inputs req[1:0] and last, and a one-hot grant output.
- FSM, counter and muxes live in the top module.

## Test plan
- Lone fetch, MEM_LAT=2:
  - stimulus: if_req=1, if_addr=0x10 in cycle 0.
  - required: if_gnt=1 and m_req=1 with m_addr=0x10, m_funct3=3'b010 in cycle 0.
  - required: if_rvalid=1 with if_rdata=m_rdata in cycle 2; back in IDLE in cycle 3.
- Simultaneous requests after reset:
  - required: fetch is granted first.
  - required: d_gnt pulses in cycle MEM_LAT+1, and d_rvalid follows MEM_LAT cycles later.
- Store:
  - stimulus: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_funct3=3'b000.
  - required: m_we=1 and m_* match the stimulus on the m_req cycle.
  - required: d_rvalid pulses MEM_LAT cycles later.
- Both reqs held continuously over 4 accesses:
  - required: grants alternate IF, D, IF, D.
  - required: m_req is spaced exactly MEM_LAT+1 cycles apart.
- Reset asserted in the cycle before the expected rvalid:
  - required: no rvalid appears and all outputs are 0 asynchronously.
  - required: after release, the arbiter accepts the next request normally.
- MEM_LAT=1 and MEM_LAT=15 builds:
  - required: the rvalid offset from gnt equals MEM_LAT exactly.
